// File: rtl/bank_cmd_sequencer_if.sv
// Request, open-row tracker and DRAM command signals of one bank sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface bank_cmd_sequencer_if #(
    parameter int ROW_WIDTH = 14,
    parameter int COL_WIDTH = 10
);
    logic                 req_valid;
    logic                 req_ready;
    logic [ROW_WIDTH-1:0] req_row;
    logic [COL_WIDTH-1:0] req_col;
    logic                 req_write;

    logic [ROW_WIDTH-1:0] current_row;
    logic                 bank_open;
    logic                 update_row;
    logic [ROW_WIDTH-1:0] new_row;
    logic                 toggle_bank;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_type;
    logic [ROW_WIDTH-1:0] cmd_row;
    logic [COL_WIDTH-1:0] cmd_col;

    modport master (
        output req_valid, req_row, req_col, req_write,
        output current_row, bank_open, cmd_ready,
        input  req_ready, update_row, new_row, toggle_bank,
        input  cmd_valid, cmd_type, cmd_row, cmd_col
    );

    modport slave (
        input  req_valid, req_row, req_col, req_write,
        input  current_row, bank_open, cmd_ready,
        output req_ready, update_row, new_row, toggle_bank,
        output cmd_valid, cmd_type, cmd_row, cmd_col
    );
endinterface

// File: rtl/bank_cmd_sequencer.sv
// Single-bank DRAM command sequencer: turns one access request into the
// PRE/ACT/RD/WR sequence implied by the open-row state, honouring tRCD/tRP/tRAS.
module bank_cmd_sequencer #(
    parameter int C_ROW_WIDTH = 14,
    parameter int C_COL_WIDTH = 10,
    parameter int C_TRCD      = 3,
    parameter int C_TRP       = 3,
    parameter int C_TRAS      = 8
) (
    input  logic                 core_clk,
    input  logic                 core_rst,
    bank_cmd_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CHECK, PRE, ACT, RW} state_t;
    typedef enum logic [1:0] {
        CMD_ACT = 2'b00,
        CMD_PRE = 2'b01,
        CMD_RD  = 2'b10,
        CMD_WR  = 2'b11
    } cmd_t;

    // The handshake cycle counts as the first elapsed cycle, so loading C-1
    // makes the dependent command presentable exactly C cycles after it.
    localparam logic [4:0] TRCD_LOAD = 5'(C_TRCD - 1);
    localparam logic [4:0] TRP_LOAD  = 5'(C_TRP - 1);
    localparam logic [4:0] TRAS_LOAD = 5'(C_TRAS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [C_ROW_WIDTH-1:0] lat_row;
    logic [C_COL_WIDTH-1:0] lat_col;
    logic                   lat_write;
    logic [4:0]             trcd_cnt;
    logic [4:0]             trp_cnt;
    logic [4:0]             tras_cnt;
    logic                   cmd_valid_c;
    logic                   accept;
    logic                   handshake;

    assign accept    = bus.req_valid && (state == IDLE);
    assign handshake = cmd_valid_c && bus.cmd_ready;

    function automatic logic [4:0] dec_floor(input logic [4:0] value);
        return (value == 5'd0) ? 5'd0 : value - 5'd1;
    endfunction

    always_ff @(posedge core_clk) begin
        // NOTE: non-blocking so every flop samples the pre-edge values of the others.
        if (core_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = CHECK;
            CHECK: begin
                if (!bus.bank_open)                  state_next = ACT;
                else if (bus.current_row == lat_row) state_next = RW;
                else                                 state_next = PRE;
            end
            PRE:     if (handshake) state_next = ACT;
            ACT:     if (handshake) state_next = RW;
            RW:      if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            lat_row   <= '0;
            lat_col   <= '0;
            lat_write <= 1'b0;
            trcd_cnt  <= 5'd0;
            trp_cnt   <= 5'd0;
            tras_cnt  <= 5'd0;
        end else begin
            if (accept) begin
                lat_row   <= bus.req_row;
                lat_col   <= bus.req_col;
                lat_write <= bus.req_write;
            end
            trcd_cnt <= dec_floor(trcd_cnt);
            trp_cnt  <= dec_floor(trp_cnt);
            tras_cnt <= dec_floor(tras_cnt);
            // Loads win over the free-running decrement above.
            if (state == PRE && handshake) begin
                trp_cnt <= TRP_LOAD;
            end
            if (state == ACT && handshake) begin
                trcd_cnt <= TRCD_LOAD;
                tras_cnt <= TRAS_LOAD;
            end
        end
    end

    always_comb begin
        cmd_valid_c  = 1'b0;
        bus.cmd_type = CMD_ACT;
        case (state)
            PRE: begin
                cmd_valid_c  = (tras_cnt == 5'd0);
                bus.cmd_type = CMD_PRE;
            end
            ACT: begin
                cmd_valid_c  = (trp_cnt == 5'd0);
                bus.cmd_type = CMD_ACT;
            end
            RW: begin
                cmd_valid_c  = (trcd_cnt == 5'd0);
                bus.cmd_type = lat_write ? CMD_WR : CMD_RD;
            end
            default: ;
        endcase
        bus.req_ready = (state == IDLE);
        bus.cmd_valid = cmd_valid_c;
        bus.cmd_row   = lat_row;
        bus.cmd_col   = lat_col;
        bus.new_row   = lat_row;
        // Tracker pulses are suppressed while reset is abandoning the request.
        bus.toggle_bank = !core_rst && cmd_valid_c && bus.cmd_ready
                          && (state == PRE || state == ACT);
        bus.update_row  = !core_rst && cmd_valid_c && bus.cmd_ready && (state == ACT);
    end

endmodule

// File: tb/tb_bank_cmd_sequencer.sv
// Directed bench for bank_cmd_sequencer: a table of single requests plus
// hand-written sequences for tRAS spacing, backpressure, reset and counter floor.
module tb_bank_cmd_sequencer;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    always #5 core_clk = ~core_clk;

    bank_cmd_sequencer_if #(.ROW_WIDTH(14), .COL_WIDTH(10)) bus ();

    bank_cmd_sequencer #(
        .C_ROW_WIDTH(14), .C_COL_WIDTH(10), .C_TRCD(3), .C_TRP(3), .C_TRAS(8)
    ) dut (
        .core_clk(core_clk),
        .core_rst(core_rst),
        .bus     (bus)
    );

    typedef struct packed {
        int          cyc;
        logic [1:0]  typ;
        logic [13:0] row;
        logic [9:0]  col;
    } ev_t;

    typedef struct {
        logic        bo;
        logic [13:0] cur;
        logic [13:0] row;
        logic [9:0]  col;
        logic        wr;
        int          n;
        logic [1:0]  typ0, typ1, typ2;
        int          off0, off1, off2;
        int          tog;
        int          upd;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   tog_cnt = 0;
    int   upd_cnt = 0;
    ev_t  ev_q[$];

    always @(posedge core_clk) cyc <= cyc + 1;

    // Handshakes and tracker pulses, ignored while reset is asserted.
    always @(negedge core_clk) begin : mon
        ev_t e;
        if (!core_rst) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                e.cyc = cyc;
                e.typ = bus.cmd_type;
                e.row = bus.cmd_row;
                e.col = bus.cmd_col;
                ev_q.push_back(e);
            end
            tog_cnt <= tog_cnt + (bus.toggle_bank ? 1 : 0);
            upd_cnt <= upd_cnt + (bus.update_row ? 1 : 0);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic next_drive();
        @(posedge core_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge core_clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) next_drive();
    endtask

    function automatic ev_t ev_at(input int idx);
        ev_t e;
        e = '0;
        e.cyc = -1000;
        if (idx < ev_q.size()) e = ev_q[idx];
        return e;
    endfunction

    task automatic issue(input logic bo, input logic [13:0] cur, input logic [13:0] row,
                         input logic [9:0] col, input logic wr, output int t);
        bit got;
        got = 0;
        t   = -1;
        bus.bank_open   = bo;
        bus.current_row = cur;
        bus.req_row     = row;
        bus.req_col     = col;
        bus.req_write   = wr;
        bus.req_valid   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (bus.req_ready) begin
                got = 1;
                t   = cyc;
                break;
            end
        end
        check("accept", got, 1);
        next_drive();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (ev_q.size() > base && ev_q[ev_q.size()-1].typ[1]) begin
                ok = 1;
                break;
            end
        end
        check("rw_done", ok, 1);
    endtask

    vec_t       vecs [5];
    vec_t       v;
    logic [1:0] et [3];
    int         eo [3];
    int         base, tb0, ub0, t, t2, a;
    bit         found;
    ev_t        e, p, c, w;

    initial begin
        vecs[0] = '{bo:1'b0, cur:14'h0,    row:14'h12,   col:10'h5,   wr:1'b0, n:2,
                    typ0:2'b00, typ1:2'b10, typ2:2'b00, off0:2, off1:5, off2:0, tog:1, upd:1};
        vecs[1] = '{bo:1'b1, cur:14'h12,   row:14'h12,   col:10'h7,   wr:1'b1, n:1,
                    typ0:2'b11, typ1:2'b00, typ2:2'b00, off0:2, off1:0, off2:0, tog:0, upd:0};
        vecs[2] = '{bo:1'b1, cur:14'h34,   row:14'h12,   col:10'h3ff, wr:1'b0, n:3,
                    typ0:2'b01, typ1:2'b00, typ2:2'b10, off0:2, off1:5, off2:8, tog:2, upd:1};
        vecs[3] = '{bo:1'b0, cur:14'h3fff, row:14'h3fff, col:10'h0,   wr:1'b1, n:2,
                    typ0:2'b00, typ1:2'b11, typ2:2'b00, off0:2, off1:5, off2:0, tog:1, upd:1};
        vecs[4] = '{bo:1'b1, cur:14'h0,    row:14'h0,    col:10'h155, wr:1'b0, n:1,
                    typ0:2'b10, typ1:2'b00, typ2:2'b00, off0:2, off1:0, off2:0, tog:0, upd:0};

        bus.req_valid   = 1'b0;
        bus.req_row     = '0;
        bus.req_col     = '0;
        bus.req_write   = 1'b0;
        bus.current_row = '0;
        bus.bank_open   = 1'b0;
        bus.cmd_ready   = 1'b1;

        // Reset state
        core_rst = 1'b1;
        gap(3);
        core_rst = 1'b0;
        sample();
        check("rst_req_ready",   bus.req_ready,   1);
        check("rst_cmd_valid",   bus.cmd_valid,   0);
        check("rst_update_row",  bus.update_row,  0);
        check("rst_toggle_bank", bus.toggle_bank, 0);
        check("rst_cmd_type",    bus.cmd_type,    0);
        check("rst_cmd_row",     bus.cmd_row,     0);
        check("rst_cmd_col",     bus.cmd_col,     0);
        check("rst_new_row",     bus.new_row,     0);

        // Table of single requests, each from a quiet bank with all counters expired
        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            et[0] = v.typ0; et[1] = v.typ1; et[2] = v.typ2;
            eo[0] = v.off0; eo[1] = v.off1; eo[2] = v.off2;
            gap(16);
            bus.cmd_ready = 1'b1;
            base = ev_q.size();
            tb0  = tog_cnt;
            ub0  = upd_cnt;
            issue(v.bo, v.cur, v.row, v.col, v.wr, t);
            wait_done(base, 40);
            check($sformatf("v%0d_ncmd", k), ev_q.size() - base, v.n);
            for (int i = 0; i < v.n; i++) begin
                e = ev_at(base + i);
                check($sformatf("v%0d_c%0d_type", k, i), e.typ, et[i]);
                check($sformatf("v%0d_c%0d_cycle", k, i), e.cyc - t, eo[i]);
                check($sformatf("v%0d_c%0d_row", k, i), e.row, v.row);
                if (et[i][1]) check($sformatf("v%0d_c%0d_col", k, i), e.col, v.col);
            end
            sample();
            check($sformatf("v%0d_idle_ready", k), bus.req_ready, 1);
            check($sformatf("v%0d_idle_valid", k), bus.cmd_valid, 0);
            check($sformatf("v%0d_toggles", k), tog_cnt - tb0, v.tog);
            check($sformatf("v%0d_updates", k), upd_cnt - ub0, v.upd);
        end

        // tRAS: a conflicting request right after an activate
        gap(16);
        bus.cmd_ready = 1'b1;
        base = ev_q.size();
        issue(1'b0, 14'h0, 14'h12, 10'h5, 1'b0, t);
        wait_done(base, 40);
        a = ev_at(base).cyc;
        check("b_first_act_cycle", a - t, 2);
        base = ev_q.size();
        tb0  = tog_cnt;
        issue(1'b1, 14'h12, 14'h34, 10'h9, 1'b1, t2);
        check("b_back_to_idle", t2 - t, 6);
        wait_done(base, 60);
        p = ev_at(base);
        c = ev_at(base + 1);
        w = ev_at(base + 2);
        check("b_ncmd", ev_q.size() - base, 3);
        check("b_pre_type", p.typ, 2'b01);
        check("b_pre_not_before_tras", (p.cyc - a) >= 8, 1);
        check("b_pre_cycle", p.cyc - a, 8);
        check("b_act_type", c.typ, 2'b00);
        check("b_act_after_pre", c.cyc - p.cyc, 3);
        check("b_act_row", c.row, 14'h34);
        check("b_wr_type", w.typ, 2'b11);
        check("b_wr_after_act", w.cyc - c.cyc, 3);
        check("b_toggles", tog_cnt - tb0, 2);

        // Backpressure in ACT for 10 cycles
        gap(16);
        bus.cmd_ready = 1'b0;
        base = ev_q.size();
        tb0  = tog_cnt;
        issue(1'b0, 14'h0, 14'h2a, 10'h11, 1'b0, t);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (bus.cmd_valid) begin
                found = 1;
                break;
            end
        end
        check("c_act_found", found, 1);
        check("c_act_first_cycle", cyc - t, 2);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) sample();
            check($sformatf("c_hold%0d", i),
                  {bus.cmd_valid, bus.cmd_type, bus.cmd_row, bus.toggle_bank, bus.update_row},
                  {1'b1, 2'b00, 14'h2a, 1'b0, 1'b0});
        end
        next_drive();
        bus.cmd_ready = 1'b1;
        sample();
        check("c_release_toggle", bus.toggle_bank, 1);
        check("c_release_update", bus.update_row, 1);
        check("c_release_new_row", bus.new_row, 14'h2a);
        wait_done(base, 20);
        e = ev_at(base);
        check("c_ncmd", ev_q.size() - base, 2);
        check("c_act_cycle", e.cyc - t, 12);
        check("c_rd_after_act", ev_at(base + 1).cyc - e.cyc, 3);
        check("c_toggles", tog_cnt - tb0, 1);

        // Reset clears loaded counters, then reset during a presented PRE
        gap(16);
        bus.cmd_ready = 1'b1;
        base = ev_q.size();
        issue(1'b0, 14'h0, 14'h5, 10'h1, 1'b0, t);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (ev_q.size() > base) begin
                found = 1;
                break;
            end
        end
        check("d_act_seen", found, 1);
        next_drive();
        core_rst = 1'b1;
        next_drive();
        core_rst = 1'b0;
        check("d_cnt_trcd", dut.trcd_cnt, 0);
        check("d_cnt_trp",  dut.trp_cnt,  0);
        check("d_cnt_tras", dut.tras_cnt, 0);
        check("d_req_ready", bus.req_ready, 1);
        check("d_cmd_valid", bus.cmd_valid, 0);

        bus.cmd_ready = 1'b0;
        base = ev_q.size();
        issue(1'b1, 14'h5, 14'h6, 10'h2, 1'b1, t);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (bus.cmd_valid && bus.cmd_type == 2'b01) begin
                found = 1;
                break;
            end
        end
        check("d_pre_presented", found, 1);
        next_drive();
        core_rst      = 1'b1;
        bus.cmd_ready = 1'b1;
        tb0 = tog_cnt;
        sample();
        check("d_rst_no_toggle", bus.toggle_bank, 0);
        check("d_rst_no_update", bus.update_row, 0);
        next_drive();
        core_rst = 1'b0;
        check("d_after_cmd_valid", bus.cmd_valid, 0);
        check("d_after_req_ready", bus.req_ready, 1);
        check("d_after_trp",  dut.trp_cnt,  0);
        check("d_after_tras", dut.tras_cnt, 0);
        check("d_after_trcd", dut.trcd_cnt, 0);
        check("d_after_no_cmd", ev_q.size() - base, 0);
        check("d_after_toggles", tog_cnt - tb0, 0);

        // Counter floor after a long idle stretch
        gap(100);
        check("e_floor_trcd", dut.trcd_cnt, 0);
        check("e_floor_trp",  dut.trp_cnt,  0);
        check("e_floor_tras", dut.tras_cnt, 0);
        bus.cmd_ready = 1'b1;
        base = ev_q.size();
        tb0  = tog_cnt;
        issue(1'b1, 14'h100, 14'h200, 10'h21, 1'b1, t);
        wait_done(base, 40);
        p = ev_at(base);
        c = ev_at(base + 1);
        w = ev_at(base + 2);
        check("e_pre_type",  p.typ, 2'b01);
        check("e_pre_cycle", p.cyc - t, 2);
        check("e_pre_row",   p.row, 14'h200);
        check("e_act_cycle", c.cyc - t, 5);
        check("e_wr_cycle",  w.cyc - t, 8);
        check("e_wr_col",    w.col, 10'h21);
        check("e_toggles",   tog_cnt - tb0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
